// File: rtl/avalon_time_writer_if.sv
// Avalon-MM write-only bus between the time writer (master) and the PIO interconnect (slave).
interface avalon_time_writer_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic              avm_waitrequest;

   modport master (
      output avm_address,
      output avm_write,
      output avm_writedata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_write,
      input  avm_writedata,
      output avm_waitrequest
   );
endinterface

// File: rtl/avalon_time_writer.sv
// Wall-clock hh:mm:ss keeper that pushes every new time to the SEC/MIN/HOUR PIO slaves.
// state   | meaning
// IDLE    | no write in flight
// WR_SEC  | writing seconds (snapshot taken on entry)
// WR_MIN  | writing minutes
// WR_HOUR | writing hours, then restart if an update is pending
module avalon_time_writer #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] SEC_ADDR  = 16'h0000,
   parameter logic [ADDR_W-1:0] MIN_ADDR  = 16'h0010,
   parameter logic [ADDR_W-1:0] HOUR_ADDR = 16'h0020
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic                        set_en,
   input  logic [4:0]                  set_hour,
   input  logic [5:0]                  set_min,
   input  logic [5:0]                  set_sec,
   avalon_time_writer_if.master        avm,
   output logic [4:0]                  hour,
   output logic [5:0]                  minute,
   output logic [5:0]                  second,
   output logic                        busy,
   output logic                        set_err,
   output logic                        tick_drop
);

   typedef enum logic [1:0] {IDLE, WR_SEC, WR_MIN, WR_HOUR} state_t;

   state_t     state_q, state_d;
   logic [4:0] hour_q, hour_d, snap_hour_q, snap_hour_d;
   logic [5:0] min_q, min_d, snap_min_q, snap_min_d;
   logic [5:0] sec_q, sec_d, snap_sec_q, snap_sec_d;
   logic       pending_q, pending_d;
   logic       set_err_q, set_err_d;
   logic       tick_drop_q, tick_drop_d;
   logic       set_ok, req, done, restart;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         hour_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         snap_hour_q <= '0;
         snap_min_q  <= '0;
         snap_sec_q  <= '0;
         pending_q   <= 1'b1;
         set_err_q   <= 1'b0;
         tick_drop_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         snap_hour_q <= snap_hour_d;
         snap_min_q  <= snap_min_d;
         snap_sec_q  <= snap_sec_d;
         pending_q   <= pending_d;
         set_err_q   <= set_err_d;
         tick_drop_q <= tick_drop_d;
      end
   end

   always_comb begin
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      snap_hour_d = snap_hour_q;
      snap_min_d  = snap_min_q;
      snap_sec_d  = snap_sec_q;
      state_d     = state_q;
      req         = 1'b0;
      restart     = 1'b0;
      set_ok      = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
      done        = (state_q != IDLE) && !avm.avm_waitrequest;

      // A set, valid or not, swallows a coincident tick.
      if (set_en) begin
         if (set_ok) begin
            hour_d = set_hour;
            min_d  = set_min;
            sec_d  = set_sec;
            req    = 1'b1;
         end
      end else if (tick) begin
         req = 1'b1;
         if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
               min_d  = '0;
               hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end

      set_err_d   = set_en && !set_ok;
      tick_drop_d = (state_q != IDLE) && req && pending_q;
      pending_d   = pending_q | ((state_q != IDLE) && req);

      case (state_q)
         IDLE:    restart = pending_q || req;
         WR_SEC:  if (done) state_d = WR_MIN;
         WR_MIN:  if (done) state_d = WR_HOUR;
         WR_HOUR: begin
            if (done) begin
               restart = pending_q || req;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The snapshot takes the post-edge time so a same-edge change is already included.
      if (restart) begin
         state_d     = WR_SEC;
         pending_d   = 1'b0;
         snap_hour_d = hour_d;
         snap_min_d  = min_d;
         snap_sec_d  = sec_d;
      end
   end

   always_comb begin
      avm.avm_write     = 1'b0;
      avm.avm_address   = '0;
      avm.avm_writedata = '0;
      case (state_q)
         WR_SEC: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = SEC_ADDR;
            avm.avm_writedata = {26'd0, snap_sec_q};
         end
         WR_MIN: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = MIN_ADDR;
            avm.avm_writedata = {26'd0, snap_min_q};
         end
         WR_HOUR: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = HOUR_ADDR;
            avm.avm_writedata = {27'd0, snap_hour_q};
         end
         default: ;
      endcase
   end

   assign hour      = hour_q;
   assign minute    = min_q;
   assign second    = sec_q;
   assign busy      = (state_q != IDLE);
   assign set_err   = set_err_q;
   assign tick_drop = tick_drop_q;

endmodule

// File: tb/tb_avalon_time_writer.sv
// Bench for avalon_time_writer: expected bus writes go to a queue and are checked as transfers complete.
module tb_avalon_time_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       set_en = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic [5:0] set_sec = '0;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic       busy, set_err, tick_drop;

   avalon_time_writer_if #(.ADDR_W(16)) bus();

   avalon_time_writer #(.ADDR_W(16)) dut (
      .clk(clk), .reset(reset), .tick(tick), .set_en(set_en),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .avm(bus), .hour(hour), .minute(minute), .second(second),
      .busy(busy), .set_err(set_err), .tick_drop(tick_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       err;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[6];
   int   total = 0;
   int   bad = 0;
   int   drops = 0;
   int   eh = 0, em = 0, es = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && tick_drop) drops++;
      if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {16'd0, bus.avm_address}, 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("write_addr", {16'd0, bus.avm_address}, {16'd0, w.addr});
            chk("write_data", bus.avm_writedata, w.data);
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input int h, input int m, input int s);
      exp_q.push_back('{16'h0000, 32'(s)});
      exp_q.push_back('{16'h0010, 32'(m)});
      exp_q.push_back('{16'h0020, 32'(h)});
   endtask

   task automatic model_tick;
      if (es == 59) begin
         es = 0;
         if (em == 59) begin
            em = 0;
            eh = (eh == 23) ? 0 : eh + 1;
         end else em++;
      end else es++;
   endtask

   task automatic chk_time(input string name);
      chk({name, "_hour"}, 32'(hour), 32'(eh));
      chk({name, "_min"}, 32'(minute), 32'(em));
      chk({name, "_sec"}, 32'(second), 32'(es));
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 200) begin
         step;
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_tick;
      tick = 1'b1;
      step;
      tick = 1'b0;
   endtask

   initial begin
      int d0;
      bus.avm_waitrequest = 1'b0;
      vecs[0] = '{5'd10, 6'd20, 6'd30, 1'b0};
      vecs[1] = '{5'd24, 6'd0,  6'd0,  1'b1};
      vecs[2] = '{5'd0,  6'd60, 6'd0,  1'b1};
      vecs[3] = '{5'd0,  6'd0,  6'd60, 1'b1};
      vecs[4] = '{5'd23, 6'd59, 6'd59, 1'b0};
      vecs[5] = '{5'd5,  6'd0,  6'd0,  1'b0};

      // Reset state and the initialising write sequence
      repeat (3) step;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_write", 32'(bus.avm_write), 32'd0);
      chk("rst_addr", 32'(bus.avm_address), 32'd0);
      chk("rst_data", bus.avm_writedata, 32'd0);
      chk("rst_err", 32'(set_err), 32'd0);
      chk("rst_drop", 32'(tick_drop), 32'd0);
      chk_time("rst");
      push_seq(0, 0, 0);
      reset = 1'b0;
      step;
      chk("init_w0_write", 32'(bus.avm_write), 32'd1);
      chk("init_w0_addr", 32'(bus.avm_address), 32'h0000);
      step;
      chk("init_w1_addr", 32'(bus.avm_address), 32'h0010);
      step;
      chk("init_w2_addr", 32'(bus.avm_address), 32'h0020);
      chk("init_w2_busy", 32'(busy), 32'd1);
      step;
      chk("init_done_busy", 32'(busy), 32'd0);
      chk("init_done_write", 32'(bus.avm_write), 32'd0);
      wait_idle;

      // Table of set requests, valid and out of range
      for (int i = 0; i < 6; i++) begin
         wait_idle;
         set_hour = vecs[i].h;
         set_min  = vecs[i].m;
         set_sec  = vecs[i].s;
         set_en   = 1'b1;
         if (!vecs[i].err) begin
            eh = vecs[i].h; em = vecs[i].m; es = vecs[i].s;
            push_seq(eh, em, es);
         end
         step;
         set_en = 1'b0;
         chk($sformatf("vec%0d_set_err", i), 32'(set_err), 32'(vecs[i].err));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(!vecs[i].err));
         chk_time($sformatf("vec%0d", i));
         step;
         chk($sformatf("vec%0d_err_clear", i), 32'(set_err), 32'd0);
      end
      wait_idle;

      // 23:59:58 then two ticks, hour wraps
      eh = 23; em = 59; es = 58;
      set_hour = 5'd23; set_min = 6'd59; set_sec = 6'd58;
      push_seq(eh, em, es);
      set_en = 1'b1;
      step;
      set_en = 1'b0;
      repeat (9) step;
      model_tick;
      push_seq(eh, em, es);
      do_tick;
      repeat (9) step;
      model_tick;
      push_seq(eh, em, es);
      do_tick;
      chk_time("wrap");
      wait_idle;

      // Stall during WR_MIN
      model_tick;
      push_seq(eh, em, es);
      do_tick;
      step;
      bus.avm_waitrequest = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("stall%0d_addr", i), 32'(bus.avm_address), 32'h0010);
         chk($sformatf("stall%0d_data", i), bus.avm_writedata, 32'(em));
         if (i < 5) step;
      end
      bus.avm_waitrequest = 1'b0;
      step;
      chk("stall_next_addr", 32'(bus.avm_address), 32'h0020);
      wait_idle;

      // Three ticks under a held waitrequest: one drop, one follow-up sequence
      d0 = drops;
      bus.avm_waitrequest = 1'b1;
      model_tick;
      push_seq(eh, em, es);
      do_tick;
      step;
      model_tick;
      do_tick;
      chk("drop_after_2nd", 32'(tick_drop), 32'd0);
      step;
      model_tick;
      do_tick;
      chk("drop_after_3rd", 32'(tick_drop), 32'd1);
      push_seq(eh, em, es);
      repeat (3) step;
      chk("drop_count", 32'(drops - d0), 32'd1);
      chk_time("drop");
      bus.avm_waitrequest = 1'b0;
      wait_idle;

      // set_en beats a coincident tick
      d0 = drops;
      eh = 12; em = 0; es = 0;
      push_seq(eh, em, es);
      set_hour = 5'd12; set_min = 6'd0; set_sec = 6'd0;
      set_en = 1'b1;
      tick = 1'b1;
      step;
      set_en = 1'b0;
      tick = 1'b0;
      chk_time("set_vs_tick");
      wait_idle;
      chk("set_vs_tick_drop", 32'(drops - d0), 32'd0);

      // Reset mid-sequence kills the write at once
      model_tick;
      push_seq(eh, em, es);
      do_tick;
      step;
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_write", 32'(bus.avm_write), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      eh = 0; em = 0; es = 0;
      push_seq(0, 0, 0);
      step;
      reset = 1'b0;
      step;
      wait_idle;
      chk_time("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avalon_time_writer.md
Name: avalon_time_writer

Overview:
- Avalon-MM write initiator that keeps wall-clock time as hours, minutes and seconds.
- On every time change it pushes the new values to three 7-bit PIO output slaves (seconds, minutes, hours).
- It is the master-side counterpart of the system's HOUR/MIN/SEC PIO slaves. It sits between the 1 Hz tick generator and the interconnect, so the display PIOs update without CPU involvement.

Parameters:
- ADDR_W, 16: master address width.
- SEC_ADDR, 16'h0000: byte address of the seconds PIO data register.
- MIN_ADDR, 16'h0010: byte address of the minutes PIO data register.
- HOUR_ADDR, 16'h0020: byte address of the hours PIO data register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse, one per second.
- set_en  in  1  one-cycle pulse; load set_* values.
- set_hour  in  5  hour to load, 0..23.
- set_min  in  6  minute to load, 0..59.
- set_sec  in  6  second to load, 0..59.
- avm_address  out  ADDR_W  write address.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- hour  out  5  current hour.
- minute  out  6  current minute.
- second  out  6  current second.
- busy  out  1  write sequence in progress.
- set_err  out  1  one-cycle pulse when a set is rejected.
- tick_drop  out  1  one-cycle pulse when an update request is coalesced.

Behaviour:
- Reset (async, active-high) values:
  - hour/minute/second = 0; avm_write = 0; avm_address = 0; avm_writedata = 0.
  - busy = 0; set_err = 0; tick_drop = 0; FSM = IDLE.
  - pending = 1, so one initialising write sequence (0,0,0) starts on the first clock after reset deasserts.
- Counting, on a tick:
  - second increments; 59 wraps to 0 with a carry to minute.
  - minute 59 wraps to 0 with a carry to hour.
  - hour 23 wraps to 0.
  - Counters update at the same edge that samples tick.
- Set:
  - If set_hour ≤ 23, set_min ≤ 59 and set_sec ≤ 59, the counters load at the sampling edge.
  - Otherwise the counters are unchanged and set_err pulses the next cycle.
  - set_en wins over a same-cycle tick; that tick is discarded, with no tick_drop.
- Update request:
  - Raised by any counter change (tick or accepted set) or by reset.
  - If FSM = IDLE, the sequence starts at the same edge.
  - If busy and pending = 0, pending is set.
  - If busy and pending = 1, tick_drop pulses and pending stays 1. Counters still advance, so the next sequence carries the latest time.
- FSM states IDLE, WR_SEC, WR_MIN, WR_HOUR:
  - On entry to WR_SEC, hour/minute/second are snapshotted into a shadow register; all three writes use the snapshot.
  - In each WR_* state: avm_write = 1, avm_address = the matching *_ADDR, avm_writedata = {zeros, field} zero-extended to 32 bits.
  - avm_address and avm_writedata stay stable while avm_waitrequest = 1.
  - A transfer completes on an edge where avm_write = 1 and avm_waitrequest = 0.
  - Then WR_SEC → WR_MIN → WR_HOUR.
  - After WR_HOUR completes: go to WR_SEC (new snapshot) if pending, clearing pending; otherwise go to IDLE.
- busy = 1 in every WR_* state.
- avm_write is never 1 in IDLE.
- With waitrequest held low, a sequence is exactly 3 cycles and the first write is visible the cycle after the request edge.
- There is no timeout; an indefinite waitrequest stalls the FSM while counting continues.
- Reset asserted mid-sequence deasserts avm_write immediately (asynchronously) and discards the snapshot.

Test Plan:
- Release reset, waitrequest = 0 → three consecutive writes: 0x0000 data 0, 0x0010 data 0, 0x0020 data 0; then busy = 0.
- set_en with 23:59:58, then two ticks spaced 10 cycles → writes carry 23:59:58, then 23:59:59, then 00:00:00; hour wraps to 0.
- set_en with set_min = 60 → set_err = 1 for one cycle, counters unchanged, no write issued.
- waitrequest high for 5 cycles during WR_MIN → avm_address = 0x0010 and data held stable for 6 cycles, then WR_HOUR follows.
- Waitrequest held high, three ticks during one sequence → tick_drop pulses exactly once; after release, exactly one further sequence runs, carrying second = start + 3.
- set_en and tick in the same cycle with set 12:00:00 → counters read 12:00:00 (tick ignored), and a sequence writes 12, 0, 0.
